// File: rtl/mat_defs_pkg.sv
// Shared definitions for the matrix-multiply sequencer: widths, saturation limits,
// FSM state encoding and the flat element-index helper.
package mat_defs;

    localparam int DW      = 8;
    localparam int NMAX    = 5;
    localparam int ACCW    = 20;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    // Element (r,c) lives at bit offset elem_idx(r,c,n)*DW in the flat packing.
    function automatic int elem_idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/matmul_sequencer_mac_unit.sv
// Combinational MAC step: signed DW x DW product added to the accumulator,
// plus int8 saturation of the incoming accumulator value with a clip flag.
module mac_unit #(
    parameter int DW   = mat_defs::DW,
    parameter int ACCW = mat_defs::ACCW
) (
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    input  logic signed [ACCW-1:0] acc_in,
    output logic signed [ACCW-1:0] sum,
    output logic [DW-1:0]          sat,
    output logic                   clip
);
    import mat_defs::*;

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] prod_ext;

    always_comb begin
        prod     = a * b;
        prod_ext = $signed({{(ACCW-2*DW){prod[2*DW-1]}}, prod});
        sum      = acc_in + prod_ext;
    end

    // Saturation looks at the accumulator register, which already holds the full dot product.
    always_comb begin
        sat  = acc_in[DW-1:0];
        clip = 1'b0;
        if (acc_in > ACCW'(SAT_MAX)) begin
            sat  = DW'(SAT_MAX);
            clip = 1'b1;
        end else if (acc_in < ACCW'(SAT_MIN)) begin
            sat  = DW'(SAT_MIN);
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one MAC unit over an NxN int8 matrix product, one MAC per cycle,
// with latched operands, saturated int8 results and a sticky overflow flag.
module matmul_sequencer #(
    parameter int DW   = mat_defs::DW,
    parameter int NMAX = mat_defs::NMAX,
    parameter int ACCW = mat_defs::ACCW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             size,
    input  logic [NMAX*NMAX*DW-1:0] mat_a,
    input  logic [NMAX*NMAX*DW-1:0] mat_b,
    output logic [NMAX*NMAX*DW-1:0] mat_c,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);
    import mat_defs::*;

    localparam int MW = NMAX * NMAX * DW;

    state_t state, state_nx;

    logic [MW-1:0]          a_reg, b_reg;
    logic [2:0]             n_reg, n_clamp;
    logic [2:0]             i, j, k;
    logic signed [ACCW-1:0] acc, acc_sum;
    logic [DW-1:0]          a_el, b_el, sat_val;
    logic                   clip;
    logic                   last_k, last_j, last_i;
    logic                   do_load, do_mac, do_write, do_done;

    always_comb begin
        if (size < 3'd2)
            n_clamp = 3'd2;
        else if (int'(size) > NMAX)
            n_clamp = 3'(NMAX);
        else
            n_clamp = size;
    end

    assign a_el = a_reg[elem_idx(int'(i), int'(k), NMAX)*DW +: DW];
    assign b_el = b_reg[elem_idx(int'(k), int'(j), NMAX)*DW +: DW];

    assign last_k = (k == n_reg - 3'd1);
    assign last_j = (j == n_reg - 3'd1);
    assign last_i = (i == n_reg - 3'd1);

    mac_unit #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .a      (a_el),
        .b      (b_el),
        .acc_in (acc),
        .sum    (acc_sum),
        .sat    (sat_val),
        .clip   (clip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  state_nx = S_MAC;
            S_MAC:   if (last_k) state_nx = S_WRITE;
            S_WRITE: state_nx = (last_i && last_j) ? S_DONE : S_MAC;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        do_load  = 1'b0;
        do_mac   = 1'b0;
        do_write = 1'b0;
        do_done  = 1'b0;
        case (state)
            S_LOAD:  do_load  = 1'b1;
            S_MAC:   do_mac   = 1'b1;
            S_WRITE: do_write = 1'b1;
            S_DONE:  do_done  = 1'b1;
            default: ;
        endcase
    end

    // Outputs are registered: busy rises on the LOAD edge, done/busy flip on the DONE edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            n_reg <= 3'd2;
            mat_c <= '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (do_load) begin
                a_reg <= mat_a;
                b_reg <= mat_b;
                n_reg <= n_clamp;
                mat_c <= '0;
                ovf   <= 1'b0;
                acc   <= '0;
                i     <= '0;
                j     <= '0;
                k     <= '0;
                busy  <= 1'b1;
            end
            if (do_mac) begin
                acc <= acc_sum;
                k   <= k + 3'd1;
            end
            if (do_write) begin
                mat_c[elem_idx(int'(i), int'(j), NMAX)*DW +: DW] <= sat_val;
                if (clip)
                    ovf <= 1'b1;
                acc <= '0;
                k   <= '0;
                if (last_j) begin
                    j <= '0;
                    i <= i + 3'd1;
                end else begin
                    j <= j + 3'd1;
                end
            end
            if (do_done) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed vector table, multi-cycle
// corner sequences and randomized runs against a plain-arithmetic reference model.
module tb_matmul_sequencer;

    localparam int MW = 200;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [2:0]    size;
    logic [MW-1:0] mat_a, mat_b, mat_c;
    logic          busy, done, ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    matmul_sequencer #(.DW(8), .NMAX(5), .ACCW(20)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .size  (size),
        .mat_a (mat_a),
        .mat_b (mat_b),
        .mat_c (mat_c),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    typedef struct {
        logic [2:0]    size;
        logic [MW-1:0] a;
        logic [MW-1:0] b;
        logic [MW-1:0] c;
        logic          ovf;
        int            lat;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [MW-1:0] setel(input logic [MW-1:0] v, input int r, input int c, input int val);
        logic [31:0] t;
        t = val;
        v[(r*5+c)*8 +: 8] = t[7:0];
        return v;
    endfunction

    function automatic int getel(input logic [MW-1:0] v, input int r, input int c);
        logic signed [7:0] x;
        x = v[(r*5+c)*8 +: 8];
        return int'(x);
    endfunction

    function automatic logic [MW-1:0] fillm(input int n, input int val);
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                v = setel(v, r, c, val);
        return v;
    endfunction

    function automatic logic [MW-1:0] ident(input int n);
        logic [MW-1:0] v;
        v = '0;
        for (int r = 0; r < n; r++)
            v = setel(v, r, r, 1);
        return v;
    endfunction

    function automatic int nclamp(input logic [2:0] sz);
        if (sz < 2) return 2;
        if (sz > 5) return 5;
        return int'(sz);
    endfunction

    function automatic int latency(input int n);
        return n * n * (n + 1) + 2;
    endfunction

    task automatic model(input int n, input logic [MW-1:0] a, input logic [MW-1:0] b,
                         output logic [MW-1:0] c, output logic ov);
        int s;
        c  = '0;
        ov = 1'b0;
        for (int r = 0; r < n; r++)
            for (int cc = 0; cc < n; cc++) begin
                s = 0;
                for (int x = 0; x < n; x++)
                    s += getel(a, r, x) * getel(b, x, cc);
                if (s > 127) begin s = 127; ov = 1'b1; end
                if (s < -128) begin s = -128; ov = 1'b1; end
                c = setel(c, r, cc, s);
            end
    endtask

    task automatic chk_v(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses start for one edge (edge 0) and returns the cycle at which done was seen.
    task automatic run_op(input logic [2:0] sz, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          output int lat, output int busy_ok);
        @(negedge clk);
        size  = sz;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat     = -1;
        busy_ok = 1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = cyc;
                if (busy !== 1'b0) busy_ok = 0;
                break;
            end
            if (busy !== 1'b1) busy_ok = 0;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] sz, input logic [MW-1:0] a,
                             input logic [MW-1:0] b, input logic [MW-1:0] c_exp,
                             input logic ov_exp, input int lat_exp);
        int lat, bok;
        run_op(sz, a, b, lat, bok);
        chk_i({tag, "_latency"}, lat, lat_exp);
        chk_v({tag, "_mat_c"}, mat_c, c_exp);
        chk_i({tag, "_ovf"}, int'(ovf), int'(ov_exp));
        chk_i({tag, "_busy_window"}, bok, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_v({tag, "_hold"}, {mat_c, done}, {c_exp, 1'b0});
    endtask

    initial begin
        logic [MW-1:0] ta, tb, tc;
        logic          tov;
        int            ndone, first, d1, d2;

        rst   = 1'b1;
        start = 1'b0;
        size  = 3'd0;
        mat_a = '0;
        mat_b = '0;

        // Directed vectors with hand-derived expectations.
        ta = '0; tb = '0;
        ta = setel(ta, 0, 0, 1); ta = setel(ta, 0, 1, 2);
        ta = setel(ta, 1, 0, 3); ta = setel(ta, 1, 1, 4);
        ta = setel(ta, 4, 4, 99); ta = setel(ta, 0, 2, 55);
        tb = setel(tb, 0, 0, 5); tb = setel(tb, 0, 1, 6);
        tb = setel(tb, 1, 0, 7); tb = setel(tb, 1, 1, 8);
        tb = setel(tb, 2, 0, -7);
        tc = '0;
        tc = setel(tc, 0, 0, 19); tc = setel(tc, 0, 1, 22);
        tc = setel(tc, 1, 0, 43); tc = setel(tc, 1, 1, 50);
        vecs[0] = '{size: 3'd2, a: ta, b: tb, c: tc, ovf: 1'b0, lat: 14};
        vecs[4] = '{size: 3'd0, a: ta, b: tb, c: tc, ovf: 1'b0, lat: 14};
        vecs[1] = '{size: 3'd3, a: fillm(5, 127), b: fillm(5, 127), c: fillm(3, 127), ovf: 1'b1, lat: 38};
        vecs[2] = '{size: 3'd2, a: fillm(2, -128), b: fillm(2, 127), c: fillm(2, -128), ovf: 1'b1, lat: 14};
        tb = '0;
        tb = setel(tb, 0, 0, -5); tb = setel(tb, 0, 1, 3);
        tb = setel(tb, 1, 0, 0);  tb = setel(tb, 1, 1, -1);
        vecs[3] = '{size: 3'd2, a: ident(2), b: tb, c: tb, ovf: 1'b0, lat: 14};
        tb = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                tb = setel(tb, r, c, (r * 5 + c) * 7 - 80);
        vecs[5] = '{size: 3'd7, a: ident(5), b: tb, c: tb, ovf: 1'b0, lat: 152};

        repeat (3) @(posedge clk);
        #1;
        chk_v("reset_state", {mat_c, busy, done, ovf}, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            run_check($sformatf("vec%0d", v), vecs[v].size, vecs[v].a, vecs[v].b,
                      vecs[v].c, vecs[v].ovf, vecs[v].lat);

        // Second start mid-run and operand change after LOAD must not disturb the run.
        ta = '0; tb = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                ta = setel(ta, r, c, int'($urandom_range(0, 15)) - 8);
                tb = setel(tb, r, c, int'($urandom_range(0, 15)) - 8);
            end
        model(3, ta, tb, tc, tov);
        @(negedge clk);
        size = 3'd3; mat_a = ta; mat_b = tb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; first = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = (cyc == 5);
            if (cyc == 6) mat_a = ~ta;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (first < 0) first = cyc;
            end
        end
        start = 1'b0;
        chk_i("restart_done_count", ndone, 1);
        chk_i("restart_done_cycle", first, 38);
        chk_v("restart_mat_c", mat_c, tc);
        chk_i("restart_ovf", int'(ovf), int'(tov));

        // Start held high: the next run samples start on the IDLE cycle after DONE.
        @(negedge clk);
        size = 3'd2; mat_a = vecs[0].a; mat_b = vecs[0].b; start = 1'b1;
        @(posedge clk);
        #1;
        d1 = -1; d2 = -1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else begin
                    d2 = cyc;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk_i("held_start_first_done", d1, 14);
        chk_i("held_start_second_done", d2, 29);
        repeat (20) @(posedge clk);
        #1;
        chk_i("held_start_no_third_run", int'(busy), 0);

        // Asynchronous reset in the middle of an N=5 run.
        @(negedge clk);
        size = 3'd5; mat_a = fillm(5, 127); mat_b = fillm(5, 127); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        chk_i("pre_reset_busy_ovf", int'({busy, ovf}), 3);
        rst = 1'b1;
        #1;
        chk_v("async_reset_clear", {mat_c, busy, done, ovf}, '0);
        @(negedge clk);
        rst = 1'b0;
        tb = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                tb = setel(tb, r, c, int'($urandom_range(0, 255)));
        run_check("post_reset", 3'd5, ident(5), tb, tb, 1'b0, 152);

        // Randomized runs against the reference model.
        for (int it = 0; it < 8; it++) begin
            logic [2:0] sz;
            int n;
            sz = 3'($urandom_range(0, 7));
            n  = nclamp(sz);
            ta = '0; tb = '0;
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    if (it % 2 == 0) begin
                        ta = setel(ta, r, c, int'($urandom_range(0, 15)) - 8);
                        tb = setel(tb, r, c, int'($urandom_range(0, 15)) - 8);
                    end else begin
                        ta = setel(ta, r, c, int'($urandom_range(0, 255)));
                        tb = setel(tb, r, c, int'($urandom_range(0, 255)));
                    end
                end
            model(n, ta, tb, tc, tov);
            run_check($sformatf("rand%0d_n%0d", it, n), sz, ta, tb, tc, tov, latency(n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
